axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
- Arbitrates the AXI read-address (AR) channel between master M0 (instruction fetch) and master M1 (data access).
- Feeds the single AR path into the bridge's address decoder, which routes the transaction to slave S0, S1 or the default slave.
- Holds the grant from address handshake until the final read-data beat completes, so the R channel always has exactly one owner.
- Uses round-robin priority and a beat counter that checks the RLAST position.

Parameters:
ID_BITS, 4, master-side ARID width
ADDR_BITS, 32, address width (matches `AXI_ADDR_BITS)
LEN_BITS, 4, ARLEN width (burst = ARLEN+1 beats, max 16)

Ports:
clk  in  1  bus clock
rst  in  1  asynchronous, active-high reset
ARVALID_M0  in  1  M0 address valid
ARID_M0  in  ID_BITS  M0 ID
ARADDR_M0  in  ADDR_BITS  M0 address
ARLEN_M0  in  LEN_BITS  M0 burst length
ARSIZE_M0  in  3  M0 size
ARBURST_M0  in  2  M0 burst type
ARREADY_M0  out  1  ready back to M0
ARVALID_M1, ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1  in  as M0  M1 request
ARREADY_M1  out  1  ready back to M1
ARVALID_S  out  1  muxed valid to decoder
ARID_S  out  ID_BITS+4  {4'b master index, ARID}
ARADDR_S  out  ADDR_BITS  muxed address
ARLEN_S  out  LEN_BITS  muxed length
ARSIZE_S  out  3  muxed size
ARBURST_S  out  2  muxed burst
ARREADY_S  in  1  ready from decoder (READY_S)
RVALID  in  1  R-channel valid, granted path
RREADY  in  1  R-channel ready, granted master
RLAST  in  1  last beat flag
grant  out  2  one-hot owner {M1,M0}; 2'b00 = none
busy  out  1  state != IDLE
len_err  out  1  sticky: RLAST position mismatch

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=00, prio=M0, beat_cnt=0, len_lat=0, len_err=0.
- Reset values of combinational outputs: ARVALID_S=0, ARREADY_M0/M1=0, payload outputs=0.
- Reset asserted mid-burst aborts immediately to the reset values above; no completion is signalled.
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - Any ARVALID_Mx high: register the winner into grant; go to ADDR next cycle (one-cycle arbitration latency).
  - Both high: winner = prio.
  - Neither high: stay in IDLE.
  - Outputs: ARVALID_S=0, both ARREADY=0.
- ADDR:
  - Drive the granted master's payload on *_S; ARVALID_S = granted ARVALID.
  - Granted ARREADY_Mx = ARREADY_S; the other master's ARREADY = 0.
  - On ARVALID_S & ARREADY_S: latch len_lat=ARLEN_S, clear beat_cnt, go to DATA.
- DATA:
  - ARVALID_S=0; grant held. Each RVALID&RREADY beat increments beat_cnt.
  - Beat with RLAST=1: go to IDLE, clear grant, set prio = the non-granted master.
  - len_err set if RLAST=1 with beat_cnt != len_lat, or beat_cnt == len_lat with RLAST=0.
  - len_err is cleared only by reset.
  - Len mismatch does not block the release; only RLAST ends the burst.
- Masters hold ARVALID and payload stable until ARREADY (AXI rule). The arbiter does not re-arbitrate while in ADDR, even if the granted ARVALID drops.
- beat_cnt is LEN_BITS wide.
- Single-beat burst (ARLEN=0): RLAST on the first beat gives the minimal path IDLE->ADDR->DATA->IDLE, with no error.
- Back-to-back: earliest next grant is the cycle after the RLAST handshake, i.e. IDLE is visited for one cycle.

Decomposition:
- Shared package axi_pkg: arb_state_e enum {IDLE, ADDR, DATA}, master index constants M0_IDX=4'd0 / M1_IDX=4'd1, and ID_S width.
- One natural sub-module: rr_arbiter2 (2-request round-robin picker: req[1:0], prio in -> one-hot gnt). The FSM and mux stay in the top module.

Test Plan:
- Single M0 request: ARVALID_M0=1, ARADDR=0x0000_0010, ARLEN=0, ARREADY_S=1 in ADDR.
  -> grant=01 one cycle after request; ARID_S={4'd0,ID}; one RLAST beat returns to IDLE; len_err=0.
- Simultaneous requests after reset: both ARVALID high.
  -> M0 granted first; after its RLAST, M1 granted next (round-robin); ARID_S upper nibble = 4'd1.
- Burst of 4: ARLEN=3, beats with RVALID/RREADY toggled, RLAST on the 4th beat.
  -> grant held throughout; M1 request during DATA sees ARREADY_M1=0 until release.
- Slow slave: ARREADY_S low 5 cycles in ADDR.
  -> ARVALID_S and payload stable; ARREADY_M0 mirrors ARREADY_S.
- Length error: ARLEN=3 but RLAST on the 2nd beat.
  -> return to IDLE; len_err=1 and stays set until rst.
- Async reset in DATA mid-burst: rst pulse.
  -> grant=00, busy=0, ARVALID_S=0 in the same cycle; a new request is accepted after deassertion.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared types and constants for the AXI read-address arbiter
//
// Purpose: arbiter FSM state encoding, master index tags carried in the
// upper nibble of ARID_S, and the helper that sizes the widened ID.
// Ports: none (package).

package axi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   // Master tag prepended to the master-side ARID so the response path can
   // route R beats back to the requester.
   localparam int         MIDX_BITS = 4;
   localparam logic [3:0] M0_IDX    = 4'd0;
   localparam logic [3:0] M1_IDX    = 4'd1;

   function automatic int id_s_bits(input int id_bits);
      return id_bits + MIDX_BITS;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin picker
//
// Purpose: combinational picker; chooses one of two requesters, breaking a
// tie with the prio input.
// Ports:
//   req  [1:0]  request vector {M1,M0}
//   prio        tie winner: 0 = M0, 1 = M1
//   gnt  [1:0]  one-hot pick {M1,M0}; 2'b00 when nothing requests

module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin AR-channel arbiter holding grant through the read burst
//
// Purpose: selects M0 (instruction fetch) or M1 (data access) onto the single
// AR path toward the address decoder and keeps that owner until the final R
// beat, so the R channel never has two owners. Counts R beats and flags a
// sticky error when RLAST does not land on beat ARLEN+1.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   AR*_M0 / AR*_M1              master request channels, ARREADY_Mx back
//   AR*_S, ARREADY_S             muxed request toward the decoder
//   RVALID, RREADY, RLAST        R-channel handshake of the granted path
//   grant                        one-hot owner {M1,M0}, 2'b00 = none
//   busy                         arbiter not idle
//   len_err                      sticky RLAST position mismatch

module axi_read_arbiter
   import axi_pkg::*;
#(
   parameter int ID_BITS   = 4,
   parameter int ADDR_BITS = 32,
   parameter int LEN_BITS  = 4
) (
   input  logic                           clk,
   input  logic                           rst,

   input  logic                           ARVALID_M0,
   input  logic [ID_BITS-1:0]             ARID_M0,
   input  logic [ADDR_BITS-1:0]           ARADDR_M0,
   input  logic [LEN_BITS-1:0]            ARLEN_M0,
   input  logic [2:0]                     ARSIZE_M0,
   input  logic [1:0]                     ARBURST_M0,
   output logic                           ARREADY_M0,

   input  logic                           ARVALID_M1,
   input  logic [ID_BITS-1:0]             ARID_M1,
   input  logic [ADDR_BITS-1:0]           ARADDR_M1,
   input  logic [LEN_BITS-1:0]            ARLEN_M1,
   input  logic [2:0]                     ARSIZE_M1,
   input  logic [1:0]                     ARBURST_M1,
   output logic                           ARREADY_M1,

   output logic                           ARVALID_S,
   output logic [ID_BITS+MIDX_BITS-1:0]   ARID_S,
   output logic [ADDR_BITS-1:0]           ARADDR_S,
   output logic [LEN_BITS-1:0]            ARLEN_S,
   output logic [2:0]                     ARSIZE_S,
   output logic [1:0]                     ARBURST_S,
   input  logic                           ARREADY_S,

   input  logic                           RVALID,
   input  logic                           RREADY,
   input  logic                           RLAST,

   output logic [1:0]                     grant,
   output logic                           busy,
   output logic                           len_err
);

   arb_state_e          state, state_nxt;
   logic [1:0]          grant_nxt;
   logic [1:0]          pick;
   logic                prio, prio_nxt;        // 0: M0 wins a tie, 1: M1 wins
   logic [LEN_BITS-1:0] beat_cnt, beat_cnt_nxt;
   logic [LEN_BITS-1:0] len_lat, len_lat_nxt;
   logic                len_err_nxt;
   logic                sel_valid;
   logic                beat;

   rr_arbiter2 u_rr (
      .req  ({ARVALID_M1, ARVALID_M0}),
      .prio (prio),
      .gnt  (pick)
   );

   assign beat = RVALID & RREADY;
   assign busy = (state != IDLE);

   // Payload mux follows the registered grant, so with no owner (including
   // reset) every payload output reads zero.
   always_comb begin
      sel_valid = 1'b0;
      ARID_S    = '0;
      ARADDR_S  = '0;
      ARLEN_S   = '0;
      ARSIZE_S  = '0;
      ARBURST_S = '0;
      if (grant[0]) begin
         sel_valid = ARVALID_M0;
         ARID_S    = {M0_IDX, ARID_M0};
         ARADDR_S  = ARADDR_M0;
         ARLEN_S   = ARLEN_M0;
         ARSIZE_S  = ARSIZE_M0;
         ARBURST_S = ARBURST_M0;
      end else if (grant[1]) begin
         sel_valid = ARVALID_M1;
         ARID_S    = {M1_IDX, ARID_M1};
         ARADDR_S  = ARADDR_M1;
         ARLEN_S   = ARLEN_M1;
         ARSIZE_S  = ARSIZE_M1;
         ARBURST_S = ARBURST_M1;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      prio_nxt     = prio;
      beat_cnt_nxt = beat_cnt;
      len_lat_nxt  = len_lat;
      len_err_nxt  = len_err;
      ARVALID_S    = 1'b0;
      ARREADY_M0   = 1'b0;
      ARREADY_M1   = 1'b0;

      case (state)
         IDLE: begin
            // Grant is registered here; the decoder sees ARVALID_S only from
            // the following cycle.
            if (|pick) begin
               grant_nxt = pick;
               state_nxt = ADDR;
            end
         end

         ADDR: begin
            // No re-arbitration here even if the owner drops ARVALID.
            ARVALID_S  = sel_valid;
            ARREADY_M0 = grant[0] & ARREADY_S;
            ARREADY_M1 = grant[1] & ARREADY_S;
            if (sel_valid && ARREADY_S) begin
               len_lat_nxt  = ARLEN_S;
               beat_cnt_nxt = '0;
               state_nxt    = DATA;
            end
         end

         DATA: begin
            if (beat) begin
               beat_cnt_nxt = beat_cnt + LEN_BITS'(1);
               // RLAST must coincide exactly with beat index len_lat; either
               // an early or a missing RLAST flags the error.
               if (RLAST != (beat_cnt == len_lat)) begin
                  len_err_nxt = 1'b1;
               end
               // Only RLAST releases the channel, mismatch or not.
               if (RLAST) begin
                  state_nxt = IDLE;
                  grant_nxt = 2'b00;
                  prio_nxt  = grant[0];   // the other master wins the next tie
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= 2'b00;
         prio     <= 1'b0;
         beat_cnt <= '0;
         len_lat  <= '0;
         len_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         prio     <= prio_nxt;
         beat_cnt <= beat_cnt_nxt;
         len_lat  <= len_lat_nxt;
         len_err  <= len_err_nxt;
      end
   end

endmodule
